// File: rtl/code_lock_param_if.sv
// Front-end to lock bundle: serial code bits and controls in, door/lockout status out.
// The master drives entry strobes; the slave (the lock) drives status.
interface code_lock_param_if;
  logic       bit_valid;
  logic       bit_in;
  logic       abort;
  logic       prog_en;
  logic       door_open;
  logic       locked_out;
  logic       attempt_fail;
  logic       prog_done;
  logic [3:0] fail_cnt;
  logic [4:0] bit_cnt;

  modport master (
    output bit_valid, bit_in, abort, prog_en,
    input  door_open, locked_out, attempt_fail, prog_done, fail_cnt, bit_cnt
  );

  modport slave (
    input  bit_valid, bit_in, abort, prog_en,
    output door_open, locked_out, attempt_fail, prog_done, fail_cnt, bit_cnt
  );
endinterface

// File: rtl/code_lock_param.sv
// Serial combination lock: framed MSB-first code entry, timed door-open window,
// failure counting with timed lockout, and code reprogramming while open.
module code_lock_param #(
  parameter int                  CODE_LEN       = 6,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 6'b101010,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  OPEN_CYCLES    = 8,
  parameter int                  LOCKOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  code_lock_param_if.slave bus
);

  localparam int TMAX  = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W = $clog2(TMAX);

  typedef enum logic [1:0] {S_ENTRY, S_OPEN, S_PROG, S_LOCKOUT} state_t;

  state_t              r_state, w_state_nx;
  logic [CODE_LEN-1:0] r_shift, w_shift_nx;
  logic [CODE_LEN-1:0] r_code,  w_code_nx;
  logic [4:0]          r_bit_cnt, w_bit_cnt_nx;
  logic [3:0]          r_fail, w_fail_nx;
  logic [TMR_W-1:0]    r_timer, w_timer_nx;
  logic                r_door, w_door_nx;
  logic                r_lock, w_lock_nx;
  logic                r_afail, w_afail_nx;
  logic                r_pdone, w_pdone_nx;

  logic [CODE_LEN-1:0] w_word;
  logic                w_last;
  logic [3:0]          w_fail_inc;

  // The word as it will look once the current bit lands in the LSB.
  assign w_word     = {r_shift[CODE_LEN-2:0], bus.bit_in};
  assign w_last     = (r_bit_cnt == 5'(CODE_LEN - 1));
  assign w_fail_inc = r_fail + 4'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_ENTRY;
      r_shift   <= '0;
      r_code    <= DEFAULT_CODE;
      r_bit_cnt <= '0;
      r_fail    <= '0;
      r_timer   <= '0;
      r_door    <= 1'b0;
      r_lock    <= 1'b0;
      r_afail   <= 1'b0;
      r_pdone   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_shift   <= w_shift_nx;
      r_code    <= w_code_nx;
      r_bit_cnt <= w_bit_cnt_nx;
      r_fail    <= w_fail_nx;
      r_timer   <= w_timer_nx;
      r_door    <= w_door_nx;
      r_lock    <= w_lock_nx;
      r_afail   <= w_afail_nx;
      r_pdone   <= w_pdone_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_shift_nx   = r_shift;
    w_code_nx    = r_code;
    w_bit_cnt_nx = r_bit_cnt;
    w_fail_nx    = r_fail;
    w_timer_nx   = r_timer;
    w_door_nx    = r_door;
    w_lock_nx    = r_lock;
    w_afail_nx   = 1'b0;
    w_pdone_nx   = 1'b0;

    unique case (r_state)
      S_ENTRY: begin
        if (bus.abort) begin
          w_bit_cnt_nx = '0;
          w_shift_nx   = '0;
        end else if (bus.bit_valid) begin
          if (w_last) begin
            w_bit_cnt_nx = '0;
            w_shift_nx   = '0;
            if (w_word == r_code) begin
              w_state_nx = S_OPEN;
              w_door_nx  = 1'b1;
              w_fail_nx  = '0;
              w_timer_nx = TMR_W'(OPEN_CYCLES - 1);
            end else begin
              w_afail_nx = 1'b1;
              w_fail_nx  = w_fail_inc;
              if (w_fail_inc == 4'(MAX_FAILS)) begin
                w_state_nx = S_LOCKOUT;
                w_lock_nx  = 1'b1;
                w_timer_nx = TMR_W'(LOCKOUT_CYCLES - 1);
              end
            end
          end else begin
            w_shift_nx   = w_word;
            w_bit_cnt_nx = r_bit_cnt + 5'd1;
          end
        end
      end

      S_OPEN: begin
        // A programming strobe takes priority over the window expiring.
        if (bus.bit_valid && bus.prog_en) begin
          w_state_nx   = S_PROG;
          w_shift_nx   = {{(CODE_LEN-1){1'b0}}, bus.bit_in};
          w_bit_cnt_nx = 5'd1;
        end else if (r_timer == '0) begin
          w_state_nx = S_ENTRY;
          w_door_nx  = 1'b0;
        end else begin
          w_timer_nx = r_timer - 1'b1;
        end
      end

      S_PROG: begin
        if (bus.abort) begin
          w_state_nx   = S_ENTRY;
          w_door_nx    = 1'b0;
          w_bit_cnt_nx = '0;
          w_shift_nx   = '0;
        end else if (bus.bit_valid) begin
          if (w_last) begin
            w_code_nx    = w_word;
            w_pdone_nx   = 1'b1;
            w_state_nx   = S_ENTRY;
            w_door_nx    = 1'b0;
            w_bit_cnt_nx = '0;
            w_shift_nx   = '0;
          end else begin
            w_shift_nx   = w_word;
            w_bit_cnt_nx = r_bit_cnt + 5'd1;
          end
        end
      end

      S_LOCKOUT: begin
        if (r_timer == '0) begin
          w_state_nx   = S_ENTRY;
          w_lock_nx    = 1'b0;
          w_fail_nx    = '0;
          w_bit_cnt_nx = '0;
        end else begin
          w_timer_nx = r_timer - 1'b1;
        end
      end

      default: w_state_nx = S_ENTRY;
    endcase
  end

  assign bus.door_open    = r_door;
  assign bus.locked_out   = r_lock;
  assign bus.attempt_fail = r_afail;
  assign bus.prog_done    = r_pdone;
  assign bus.fail_cnt     = r_fail;
  assign bus.bit_cnt      = r_bit_cnt;

endmodule

// File: tb/tb_code_lock_param.sv
// Bench for code_lock_param: per-cycle expectations queued at drive time and
// checked one edge later; table vectors plus hand-built multi-cycle scenarios.
module tb_code_lock_param;

  localparam logic [5:0] DEF_CODE  = 6'b101010;
  localparam logic [3:0] MAX_FAILS = 4'd3;

  logic clk;
  logic reset;
  logic rst_lvl;

  code_lock_param_if b();

  code_lock_param #(
    .CODE_LEN(6), .DEFAULT_CODE(6'b101010), .MAX_FAILS(3),
    .OPEN_CYCLES(8), .LOCKOUT_CYCLES(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic bv, bi, ab, pe, d, l, af, pd;
    logic [3:0] fc;
    logic [4:0] bc;
    string nm;
  } vec_t;

  typedef struct {
    logic [12:0] v;
    string       nm;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   tests;
  int   fails;
  logic [5:0] exp_code;
  logic [3:0] cur_fail;

  function automatic void add(input logic bv, bi, ab, pe, d, l, af, pd,
                              input logic [3:0] fc, input logic [4:0] bc, input string nm);
    vec_t v;
    v.bv = bv; v.bi = bi; v.ab = ab; v.pe = pe;
    v.d = d; v.l = l; v.af = af; v.pd = pd;
    v.fc = fc; v.bc = bc; v.nm = nm;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic bv, bi, ab, pe, d, l, af, pd,
                      input logic [3:0] fc, input logic [4:0] bc, input string nm);
    sb_t e;
    logic [12:0] act;
    reset       = rst_lvl;
    b.bit_valid = bv;
    b.bit_in    = bi;
    b.abort     = ab;
    b.prog_en   = pe;
    sb.push_back('{{d, l, af, pd, fc, bc}, nm});
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    act = {b.door_open, b.locked_out, b.attempt_fail, b.prog_done, b.fail_cnt, b.bit_cnt};
    tests++;
    if (act !== e.v) begin
      fails++;
      $display("FAIL %s: actual door=%b lock=%b afail=%b pdone=%b fail_cnt=%0d bit_cnt=%0d, expected door=%b lock=%b afail=%b pdone=%b fail_cnt=%0d bit_cnt=%0d",
               e.nm, act[12], act[11], act[10], act[9], act[8:5], act[4:0],
               e.v[12], e.v[11], e.v[10], e.v[9], e.v[8:5], e.v[4:0]);
    end
  endtask

  task automatic reset_step(input string nm);
    rst_lvl = 1'b0;
    step(1, 1, 0, 1, 0, 0, 0, 0, 4'd0, 5'd0, nm);
    rst_lvl  = 1'b1;
    cur_fail = 4'd0;
    exp_code = DEF_CODE;
  endtask

  task automatic idle(input int n, input string nm);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, cur_fail, 5'd0, nm);
  endtask

  // Full framed attempt on consecutive cycles from ENTRY.
  task automatic attempt(input logic [5:0] c, input string nm);
    for (int i = 5; i >= 0; i--) begin
      if (i > 0) begin
        step(1, c[i], 0, 0, 0, 0, 0, 0, cur_fail, 5'(6 - i), nm);
      end else if (c == exp_code) begin
        cur_fail = 4'd0;
        step(1, c[0], 0, 0, 1, 0, 0, 0, 4'd0, 5'd0, {nm, "_open"});
      end else begin
        cur_fail = cur_fail + 4'd1;
        step(1, c[0], 0, 0, 0, cur_fail == MAX_FAILS, 1, 0, cur_fail, 5'd0, {nm, "_fail"});
      end
    end
  endtask

  // Remaining 7 open cycles after the opening edge, then closed.
  task automatic wait_open(input string nm);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, 0, 0, 0, 4'd0, 5'd0, {nm, "_held"});
    step(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 5'd0, {nm, "_closed"});
  endtask

  initial begin
    tests = 0; fails = 0;
    exp_code = DEF_CODE; cur_fail = 4'd0;
    rst_lvl = 1'b0; reset = 1'b0;
    b.bit_valid = 1'b0; b.bit_in = 1'b0; b.abort = 1'b0; b.prog_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_step("reset_state");

    // Correct code opens for 8 cycles; abort alone and abort-with-bit.
    add(1,1,0,0, 0,0,0,0, 0, 1, "c1_b1");
    add(1,0,0,0, 0,0,0,0, 0, 2, "c1_b2");
    add(1,1,0,0, 0,0,0,0, 0, 3, "c1_b3");
    add(1,0,0,0, 0,0,0,0, 0, 4, "c1_b4");
    add(1,1,0,0, 0,0,0,0, 0, 5, "c1_b5");
    add(1,0,0,0, 1,0,0,0, 0, 0, "c1_open");
    for (int i = 0; i < 7; i++) add(1,1,0,0, 1,0,0,0, 0, 0, "c1_open_ignores_bits");
    add(0,0,0,0, 0,0,0,0, 0, 0, "c1_closed");
    add(1,1,0,0, 0,0,0,0, 0, 1, "ab_b1");
    add(1,0,0,0, 0,0,0,0, 0, 2, "ab_b2");
    add(1,1,0,0, 0,0,0,0, 0, 3, "ab_b3");
    add(0,0,1,0, 0,0,0,0, 0, 0, "ab_abort");
    add(1,1,0,0, 0,0,0,0, 0, 1, "ab2_b1");
    add(1,0,0,0, 0,0,0,0, 0, 2, "ab2_b2");
    add(1,1,1,0, 0,0,0,0, 0, 0, "ab2_abort_with_bit");
    add(1,1,0,0, 0,0,0,0, 0, 1, "ab3_b1");
    add(1,0,0,0, 0,0,0,0, 0, 2, "ab3_b2");
    add(1,1,0,0, 0,0,0,0, 0, 3, "ab3_b3");
    add(1,0,0,0, 0,0,0,0, 0, 4, "ab3_b4");
    add(1,1,0,0, 0,0,0,0, 0, 5, "ab3_b5");
    add(1,0,0,0, 1,0,0,0, 0, 0, "ab3_open");
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].bv, tbl[i].bi, tbl[i].ab, tbl[i].pe, tbl[i].d, tbl[i].l,
           tbl[i].af, tbl[i].pd, tbl[i].fc, tbl[i].bc, tbl[i].nm);
    wait_open("ab3");

    // Three failures -> 16-cycle lockout that ignores a correct code.
    attempt(6'b111111, "lk1");
    attempt(6'b111111, "lk2");
    attempt(6'b111111, "lk3");
    for (int i = 1; i <= 15; i++)
      step(i <= 6, DEF_CODE[6 - ((i <= 6) ? i : 6)], i == 10, i == 11, 0, 1, 0, 0, 4'd3, 5'd0, "lockout_held");
    step(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 5'd0, "lockout_end");
    cur_fail = 4'd0;
    attempt(DEF_CODE, "post_lockout");
    wait_open("post_lockout");

    // Reprogram to 110011 while open.
    attempt(DEF_CODE, "pg");
    step(1, 1, 0, 1, 1, 0, 0, 0, 4'd0, 5'd1, "prog_b1");
    step(1, 1, 0, 0, 1, 0, 0, 0, 4'd0, 5'd2, "prog_b2");
    step(1, 0, 0, 0, 1, 0, 0, 0, 4'd0, 5'd3, "prog_b3");
    step(1, 0, 0, 0, 1, 0, 0, 0, 4'd0, 5'd4, "prog_b4");
    step(1, 1, 0, 0, 1, 0, 0, 0, 4'd0, 5'd5, "prog_b5");
    step(1, 1, 0, 0, 0, 0, 0, 1, 4'd0, 5'd0, "prog_commit");
    exp_code = 6'b110011;
    idle(1, "prog_pulse_end");
    attempt(DEF_CODE, "old_code");
    attempt(6'b110011, "new_code");
    wait_open("new_code");

    // Abort during programming keeps the existing code.
    attempt(6'b110011, "pa");
    step(1, 0, 0, 1, 1, 0, 0, 0, 4'd0, 5'd1, "pa_b1");
    step(1, 1, 0, 0, 1, 0, 0, 0, 4'd0, 5'd2, "pa_b2");
    step(1, 1, 1, 0, 0, 0, 0, 0, 4'd0, 5'd0, "pa_abort");
    attempt(6'b110011, "pa_code_kept");
    wait_open("pa_code_kept");

    // Two failures then success clears the count; one more failure no lockout.
    attempt(6'b000000, "w1");
    attempt(6'b000001, "w2");
    attempt(6'b110011, "w3_ok");
    wait_open("w3_ok");
    attempt(6'b111111, "w4");
    idle(2, "w4_no_lockout");

    // Reset mid-programming reverts the code.
    attempt(6'b110011, "rp");
    step(1, 0, 0, 1, 1, 0, 0, 0, 4'd1 - 4'd1, 5'd1, "rp_b1");
    step(1, 0, 0, 0, 1, 0, 0, 0, 4'd0, 5'd2, "rp_b2");
    step(1, 0, 0, 0, 1, 0, 0, 0, 4'd0, 5'd3, "rp_b3");
    reset_step("reset_mid_prog");
    attempt(6'b110011, "rp_new_gone");
    attempt(DEF_CODE, "rp_default_back");
    wait_open("rp_default_back");

    // Reset mid-lockout.
    attempt(6'b000000, "rl1");
    attempt(6'b000000, "rl2");
    attempt(6'b000000, "rl3");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 4'd3, 5'd0, "rl_lockout");
    reset_step("reset_mid_lockout");
    attempt(DEF_CODE, "rl_after");
    wait_open("rl_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
